sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Synthesizable SDRAM device model: the responder end of the controller-to-SDRAM pin interface (addr/ba/cs_n/ras_n/cas_n/we_n/cke/dqm/dq).
- Decodes SDRAM commands, tracks per-bank open rows, and stores data in a small on-chip array.
- Returns read data at the programmed CAS latency.
- Flags protocol and timing violations.
- Used in simulation and on-board loopback to verify the Nios SDRAM controller without the external part.

Parameters:
- ROW_W, 13, row/address bus width
- COL_W, 10, column bits taken from addr on READ/WRITE
- DQ_W, 16, data width (multiple of 8)
- ROW_USE, 4, low row bits used in the storage index
- COL_USE, 6, low column bits used in the storage index (array depth = 2^(2+ROW_USE+COL_USE) words)
- T_RCD, 3, minimum cycles from ACTIVE to READ/WRITE on the same bank
- T_RP, 3, minimum cycles from PRECHARGE to ACTIVE on the same bank

Ports:
- clk_clk  in  1  sole clock
- reset_reset  in  1  synchronous, active-high reset
- sdram_addr  in  ROW_W  address
- sdram_ba  in  2  bank
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  in  1 each  command
- sdram_cke  in  1  clock enable
- sdram_dqm  in  DQ_W/8  byte masks
- sdram_dq_i  in  DQ_W  write data
- sdram_dq_o  out  DQ_W  read data
- sdram_dq_oe  out  DQ_W/8  per-byte output enable (top level builds the tristate)
- cas_latency  out  2  current CL
- mode_valid  out  1  mode register loaded
- refresh_count  out  16  AUTO REFRESH count, wraps
- err_flags  out  4  sticky: [0] access to idle bank, [1] ACTIVE to open bank, [2] mode error, [3] timing error
- err_clr  in  1  clears err_flags

Behaviour:
- Reset values:
  - dq_o=0, dq_oe=0, cas_latency=3, mode_valid=0, refresh_count=0, err_flags=0.
  - All banks IDLE; read pipeline flushed.
  - Storage array contents are not cleared.
  - Reset mid-burst drops pending read data; dq_oe=0 the cycle after reset is sampled.
- Command decoding:
  - Commands are sampled on rising edges.
  - cs_n=1 is NOP.
  - Decode {ras_n,cas_n,we_n}: 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO REFRESH, 000 LOAD MODE, 111 NOP, 110 NOP (burst terminate not supported).
- Clock suspend: cke=0 ignores the command and freezes the read pipeline and timers; dq_o/dq_oe hold their values.
- Per-bank FSM, states IDLE and ACTIVE(row):
  - ACTIVE on IDLE: latch the row, go ACTIVE, start the tRCD counter.
  - ACTIVE on ACTIVE: set err[1]; the row is replaced.
  - ACTIVE before T_RP cycles have elapsed since PRECHARGE: set err[3].
  - PRECHARGE with addr[10]=1 closes all banks; addr[10]=0 closes bank ba only. Start the tRP counter(s).
- READ/WRITE:
  - Require mode_valid; otherwise set err[2] and perform no access.
  - Target bank IDLE: set err[0] and perform no access.
  - Issued before T_RCD cycles have elapsed since ACTIVE: set err[3], but the access is still performed.
  - Storage index = {ba, row[ROW_USE-1:0], addr[COL_USE-1:0]}.
  - addr[10]=1 is auto-precharge: the bank goes IDLE after the access and its tRP counter starts.
- WRITE: stores sdram_dq_i bytes whose dqm bit is 0 at the command edge; dqm=1 bytes are left unchanged.
- READ timing:
  - The array is read at command edge T.
  - dq_o/dq_oe are registered so they become valid after edge T+CL-1 and are sampled by the controller at edge T+CL.
  - Driven for exactly one cycle.
  - dq_oe byte = NOT dqm sampled with the READ.
- Back-to-back READs pipeline at one word per cycle.
- WRITE at T followed by READ at T+1 to the same address returns the new data.
- LOAD MODE:
  - Legal only when all banks are IDLE; otherwise set err[2] and ignore.
  - addr[6:4] must be 010 or 011 (CL 2/3) and addr[2:0] must be 000 (burst length 1); otherwise set err[2] and leave mode unchanged.
  - Legal LOAD MODE sets cas_latency and mode_valid=1.
  - Burst length 1 is the only supported burst length.
- AUTO REFRESH: refresh_count+1, wraps at 16 bits. Any bank not IDLE sets err[0].
- Error flags: in the same cycle as err_clr, a newly detected error wins (its bit is set); all other bits clear.
- Only one command exists per cycle, so there are no simultaneous-command conflicts.

Decomposition:
- Package sdram_resp_pkg:
  - command enum (NOP, ACTIVE, READ, WRITE, PRECHARGE, REFRESH, LOAD_MODE)
  - err bit index constants
  - mode-field bit positions
  - legal CL codes
- One sub-module, sdram_bank_tracker, instantiated 4 times. Per bank it holds the IDLE/ACTIVE state, open row, and saturating tRCD/tRP counters, and reports is_open, rcd_ok, rp_ok.
- Storage array and read pipeline live in the top module.

Test Plan:
- LOAD MODE addr=0x030, then ACTIVE b1 row 5, wait 3, WRITE col 7 data 0xBEEF dqm=00, READ col 7 -> dq_o=0xBEEF with oe=11 valid after edge T+2, sampled at T+3; err_flags=0.
- CL=2 (addr=0x020): READ at T -> data valid after edge T+1, sampled at T+2; three back-to-back READs of 0x1111/0x2222/0x3333 -> one word per cycle, in order.
- WRITE 0xBEEF, then WRITE 0x1234 with dqm=01 -> READ returns 0x12EF; READ with dqm=10 -> dq_oe=01.
- READ to a bank never activated -> err_flags=0001, dq_oe stays 0; READ 1 cycle after ACTIVE -> err[3] set; err_clr -> 0000.
- LOAD MODE with a bank open, or with CL code 001 -> err[2] set, cas_latency unchanged; 5 AUTO REFRESH with all banks idle -> refresh_count=5.
- cke=0 for 2 cycles during a CL=3 read -> data appears 2 cycles later; reset asserted mid-read -> dq_oe=0 next cycle, previously written data still readable after re-init.

Source files
------------

// File: rtl/sdram_responder_pkg.sv
// Shared command encoding, error bit positions and mode-register field layout
// for the SDRAM responder.
package sdram_resp_pkg;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACTIVE,
        CMD_READ,
        CMD_WRITE,
        CMD_PRECHARGE,
        CMD_REFRESH,
        CMD_LOAD_MODE
    } cmd_e;

    localparam int ERR_IDLE_BANK = 0;
    localparam int ERR_ACT_OPEN  = 1;
    localparam int ERR_MODE      = 2;
    localparam int ERR_TIMING    = 3;

    localparam int MODE_CL_LSB = 4;
    localparam int MODE_CL_MSB = 6;
    localparam int MODE_BL_MSB = 2;
    localparam int AP_BIT      = 10;

    localparam logic [2:0] CL_CODE_2 = 3'b010;
    localparam logic [2:0] CL_CODE_3 = 3'b011;

    function automatic cmd_e decode_cmd(input logic cs_n, input logic ras_n,
                                        input logic cas_n, input logic we_n);
        cmd_e c;
        c = CMD_NOP;
        if (!cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  c = CMD_ACTIVE;
                3'b101:  c = CMD_READ;
                3'b100:  c = CMD_WRITE;
                3'b010:  c = CMD_PRECHARGE;
                3'b001:  c = CMD_REFRESH;
                3'b000:  c = CMD_LOAD_MODE;
                default: c = CMD_NOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/sdram_responder_if.sv
// Controller-to-SDRAM pin bundle; the controller is the master, the device model the slave.
interface sdram_responder_if #(
    parameter int ROW_W = 13,
    parameter int DQ_W  = 16
);
    logic [ROW_W-1:0]  addr;
    logic [1:0]        ba;
    logic              cs_n;
    logic              ras_n;
    logic              cas_n;
    logic              we_n;
    logic              cke;
    logic [DQ_W/8-1:0] dqm;
    logic [DQ_W-1:0]   dq_i;
    logic [DQ_W-1:0]   dq_o;
    logic [DQ_W/8-1:0] dq_oe;

    modport master (
        output addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm, dq_i,
        input  dq_o, dq_oe
    );

    modport slave (
        input  addr, ba, cs_n, ras_n, cas_n, we_n, cke, dqm, dq_i,
        output dq_o, dq_oe
    );
endinterface

// File: rtl/sdram_responder_bank_tracker.sv
// One SDRAM bank: open/idle state, latched row and saturating tRCD/tRP timers.
// Timers advance only on clock-enabled cycles so clock suspend freezes them.
module sdram_bank_tracker #(
    parameter int ROW_W = 13,
    parameter int T_RCD = 3,
    parameter int T_RP  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_act,
    input  logic             i_pre,
    input  logic [ROW_W-1:0] i_row,
    output logic             o_open,
    output logic [ROW_W-1:0] o_row,
    output logic             o_rcd_ok,
    output logic             o_rp_ok
);
    localparam int TMAX = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int CW   = $clog2(((TMAX > 1) ? TMAX : 1) + 1);
    localparam logic [CW-1:0] RCD_SAT = CW'(T_RCD);
    localparam logic [CW-1:0] RP_SAT  = CW'(T_RP);

    logic          r_open;
    logic [CW-1:0] r_rcd_cnt;
    logic [CW-1:0] r_rp_cnt;
    logic [ROW_W-1:0] r_row;

    // Counter holds the number of enabled edges since the command, capped at the limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_open    <= 1'b0;
            r_rcd_cnt <= RCD_SAT;
            r_rp_cnt  <= RP_SAT;
        end else if (i_en) begin
            if (i_act) begin
                r_open    <= 1'b1;
                r_rcd_cnt <= CW'(1);
            end else if (r_rcd_cnt < RCD_SAT) begin
                r_rcd_cnt <= r_rcd_cnt + CW'(1);
            end
            if (i_pre) begin
                r_open   <= 1'b0;
                r_rp_cnt <= CW'(1);
            end else if (r_rp_cnt < RP_SAT) begin
                r_rp_cnt <= r_rp_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_en && i_act) begin
            r_row <= i_row;
        end
    end

    assign o_open   = r_open;
    assign o_row    = r_row;
    assign o_rcd_ok = (r_rcd_cnt >= RCD_SAT);
    assign o_rp_ok  = (r_rp_cnt >= RP_SAT);
endmodule

// File: rtl/sdram_responder.sv
// Synthesizable SDRAM device model: command decode, four bank trackers,
// byte-masked storage and a CAS-latency read pipeline with sticky error flags.
module sdram_responder
    import sdram_resp_pkg::*;
#(
    parameter int ROW_W   = 13,
    parameter int COL_W   = 10,
    parameter int DQ_W    = 16,
    parameter int ROW_USE = 4,
    parameter int COL_USE = 6,
    parameter int T_RCD   = 3,
    parameter int T_RP    = 3
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    sdram_responder_if.slave   sdram,
    output logic [1:0]         cas_latency,
    output logic               mode_valid,
    output logic [15:0]        refresh_count,
    output logic [3:0]         err_flags,
    input  logic               err_clr
);
    localparam int NB = DQ_W / 8;
    localparam int AW = 2 + ROW_USE + COL_USE;

    cmd_e             w_cmd;
    logic [3:0]       w_open, w_rcd_ok, w_rp_ok, w_act, w_pre;
    logic [ROW_W-1:0] w_row [4];
    logic [COL_W-1:0] w_col;
    logic [AW-1:0]    w_idx;
    logic [3:0]       w_new_err;
    logic             w_rd, w_wr, w_mode_ld, w_mode_ok;
    logic             w_out_vld;
    logic [NB-1:0]    w_out_oe;
    logic [DQ_W-1:0]  w_out_data;
    logic             w_unused_bits;

    logic [DQ_W-1:0]  r_mem [2**AW];
    logic [1:0]       r_cl;
    logic             r_mode_valid;
    logic [15:0]      r_ref_cnt;
    logic [3:0]       r_err;
    logic             r_vld_p0, r_vld_p1;
    logic [NB-1:0]    r_oe_p0, r_oe_p1;
    logic [DQ_W-1:0]  r_data_p0, r_data_p1;
    logic [DQ_W-1:0]  r_dq_o;
    logic [NB-1:0]    r_dq_oe;

    assign w_cmd = sdram.cke ? decode_cmd(sdram.cs_n, sdram.ras_n, sdram.cas_n, sdram.we_n)
                             : CMD_NOP;

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_bank_tracker #(.ROW_W(ROW_W), .T_RCD(T_RCD), .T_RP(T_RP)) u_bank (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .i_en     (sdram.cke),
            .i_act    (w_act[b]),
            .i_pre    (w_pre[b]),
            .i_row    (sdram.addr),
            .o_open   (w_open[b]),
            .o_row    (w_row[b]),
            .o_rcd_ok (w_rcd_ok[b]),
            .o_rp_ok  (w_rp_ok[b])
        );
    end

    assign w_col     = sdram.addr[COL_W-1:0];
    assign w_idx     = {sdram.ba, w_row[sdram.ba][ROW_USE-1:0], w_col[COL_USE-1:0]};
    assign w_mode_ok = ((sdram.addr[MODE_CL_MSB:MODE_CL_LSB] == CL_CODE_2) ||
                        (sdram.addr[MODE_CL_MSB:MODE_CL_LSB] == CL_CODE_3)) &&
                       (sdram.addr[MODE_BL_MSB:0] == '0);
    assign w_unused_bits = ^{w_col, w_row[0], w_row[1], w_row[2], w_row[3], sdram.addr};

    always_comb begin
        w_new_err = '0;
        w_act     = '0;
        w_pre     = '0;
        w_rd      = 1'b0;
        w_wr      = 1'b0;
        w_mode_ld = 1'b0;
        case (w_cmd)
            CMD_ACTIVE: begin
                w_act[sdram.ba] = 1'b1;
                if (w_open[sdram.ba])   w_new_err[ERR_ACT_OPEN] = 1'b1;
                if (!w_rp_ok[sdram.ba]) w_new_err[ERR_TIMING]   = 1'b1;
            end
            CMD_READ, CMD_WRITE: begin
                if (!r_mode_valid) begin
                    w_new_err[ERR_MODE] = 1'b1;
                end else if (!w_open[sdram.ba]) begin
                    w_new_err[ERR_IDLE_BANK] = 1'b1;
                end else begin
                    w_rd = (w_cmd == CMD_READ);
                    w_wr = (w_cmd == CMD_WRITE);
                    if (!w_rcd_ok[sdram.ba])   w_new_err[ERR_TIMING] = 1'b1;
                    if (sdram.addr[AP_BIT])   w_pre[sdram.ba]        = 1'b1;
                end
            end
            CMD_PRECHARGE: begin
                if (sdram.addr[AP_BIT]) w_pre = 4'hF;
                else                    w_pre[sdram.ba] = 1'b1;
            end
            CMD_REFRESH: begin
                if (|w_open) w_new_err[ERR_IDLE_BANK] = 1'b1;
            end
            CMD_LOAD_MODE: begin
                if ((|w_open) || !w_mode_ok) w_new_err[ERR_MODE] = 1'b1;
                else                          w_mode_ld = 1'b1;
            end
            default: ;
        endcase
    end

    // Stage p0: array access at the command edge; p1: extra delay for CL=3
    always_ff @(posedge clk_clk) begin
        if (sdram.cke) begin
            if (w_wr) begin
                for (int b = 0; b < NB; b++) begin
                    if (!sdram.dqm[b]) r_mem[w_idx][b*8 +: 8] <= sdram.dq_i[b*8 +: 8];
                end
            end
            if (w_rd) begin
                r_data_p0 <= r_mem[w_idx];
                r_oe_p0   <= ~sdram.dqm;
            end
            r_data_p1 <= r_data_p0;
            r_oe_p1   <= r_oe_p0;
        end
    end

    assign w_out_vld  = (r_cl == 2'd2) ? r_vld_p0  : r_vld_p1;
    assign w_out_oe   = (r_cl == 2'd2) ? r_oe_p0   : r_oe_p1;
    assign w_out_data = (r_cl == 2'd2) ? r_data_p0 : r_data_p1;

    // Output stage: pins are driven for exactly one enabled cycle per READ
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_cl         <= 2'd3;
            r_mode_valid <= 1'b0;
            r_ref_cnt    <= '0;
            r_err        <= '0;
            r_vld_p0     <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_dq_o       <= '0;
            r_dq_oe      <= '0;
        end else begin
            r_err <= (err_clr ? 4'h0 : r_err) | w_new_err;
            if (sdram.cke) begin
                if (w_mode_ld) begin
                    r_cl         <= sdram.addr[MODE_CL_LSB+1:MODE_CL_LSB];
                    r_mode_valid <= 1'b1;
                end
                if (w_cmd == CMD_REFRESH) r_ref_cnt <= r_ref_cnt + 16'd1;
                r_vld_p0 <= w_rd;
                r_vld_p1 <= r_vld_p0;
                r_dq_oe  <= w_out_vld ? w_out_oe   : '0;
                r_dq_o   <= w_out_vld ? w_out_data : '0;
            end
        end
    end

    assign sdram.dq_o    = r_dq_o;
    assign sdram.dq_oe   = r_dq_oe;
    assign cas_latency   = r_cl;
    assign mode_valid    = r_mode_valid;
    assign refresh_count = r_ref_cnt;
    assign err_flags     = r_err;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: a cycle table of commands with expected
// post-edge outputs, then hand sequences for clock suspend and mid-read reset.
module tb_sdram_responder;
    localparam int ROW_W = 13;
    localparam int DQ_W  = 16;

    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_LMR = 4'b0000;

    typedef struct {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic [1:0]  dqm;
        logic [15:0] dq;
        logic        clr;
        logic [1:0]  e_oe;
        logic [15:0] e_dq;
        logic [3:0]  e_err;
        logic [1:0]  e_cl;
        logic [15:0] e_ref;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err_clr = 1'b0;
    logic [1:0]  cas_latency;
    logic        mode_valid;
    logic [15:0] refresh_count;
    logic [3:0]  err_flags;
    int          n_tests = 0;
    int          n_fail  = 0;
    vec_t        tbl[$];

    sdram_responder_if #(.ROW_W(ROW_W), .DQ_W(DQ_W)) bus ();

    sdram_responder #(.ROW_W(ROW_W), .DQ_W(DQ_W)) dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .sdram         (bus),
        .cas_latency   (cas_latency),
        .mode_valid    (mode_valid),
        .refresh_count (refresh_count),
        .err_flags     (err_flags),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] cmd, input logic [1:0] ba,
                                input logic [12:0] addr, input logic [1:0] dqm,
                                input logic [15:0] dq, input logic clr,
                                input logic [1:0] e_oe, input logic [15:0] e_dq,
                                input logic [3:0] e_err, input logic [1:0] e_cl,
                                input logic [15:0] e_ref);
        vec_t v;
        v.cmd = cmd; v.ba = ba; v.addr = addr; v.dqm = dqm; v.dq = dq; v.clr = clr;
        v.e_oe = e_oe; v.e_dq = e_dq; v.e_err = e_err; v.e_cl = e_cl; v.e_ref = e_ref;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] addr,
                       input logic [1:0] dqm, input logic [15:0] dq,
                       input logic cke, input logic clr);
        {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = cmd;
        bus.ba   = ba;
        bus.addr = addr;
        bus.dqm  = dqm;
        bus.dq_i = dq;
        bus.cke  = cke;
        err_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        cyc(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} = C_NOP;
        bus.ba = '0; bus.addr = '0; bus.dqm = '0; bus.dq_i = '0; bus.cke = 1'b1;

        nop();
        nop();
        check("reset dq_oe", 32'(bus.dq_oe), 32'h0);
        check("reset dq_o", 32'(bus.dq_o), 32'h0);
        check("reset cas_latency", 32'(cas_latency), 32'd3);
        check("reset mode_valid", 32'(mode_valid), 32'd0);
        check("reset refresh_count", 32'(refresh_count), 32'd0);
        check("reset err_flags", 32'(err_flags), 32'h0);
        rst = 1'b0;

        //                 cmd    ba    addr     dqm    dq       clr   oe     dq       err   cl    ref
        tbl.push_back(mk(C_RD,  2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h4, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_LMR, 2'd0, 13'h030, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_WR,  2'd1, 13'h007, 2'b00, 16'hBEEF, 1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_RD,  2'd1, 13'h007, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b11, 16'hBEEF, 4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_WR,  2'd1, 13'h007, 2'b01, 16'h1234, 1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_RD,  2'd1, 13'h007, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_RD,  2'd1, 13'h007, 2'b10, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b11, 16'h12EF, 4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b01, 16'h12EF, 4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_RD,  2'd2, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h1, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h1, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h1, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_ACT, 2'd2, 13'h001, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_WR,  2'd2, 13'h000, 2'b00, 16'h5A5A, 1'b0, 2'b00, 16'h0,    4'h8, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_RD,  2'd2, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b11, 16'h5A5A, 4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_LMR, 2'd0, 13'h020, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h4, 2'd3, 16'd0));
        tbl.push_back(mk(C_PRE, 2'd0, 13'h400, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd3, 16'd0));
        tbl.push_back(mk(C_LMR, 2'd0, 13'h010, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h4, 2'd3, 16'd0));
        tbl.push_back(mk(C_REF, 2'd0, 13'h000, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd3, 16'd1));
        tbl.push_back(mk(C_REF, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd2));
        tbl.push_back(mk(C_REF, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd3));
        tbl.push_back(mk(C_REF, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd4));
        tbl.push_back(mk(C_REF, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd3, 16'd5));
        tbl.push_back(mk(C_LMR, 2'd0, 13'h020, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_ACT, 2'd0, 13'h003, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_WR,  2'd0, 13'h001, 2'b00, 16'h1111, 1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_WR,  2'd0, 13'h002, 2'b00, 16'h2222, 1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_WR,  2'd0, 13'h003, 2'b00, 16'h3333, 1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_RD,  2'd0, 13'h001, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_RD,  2'd0, 13'h002, 2'b00, 16'h0,    1'b0, 2'b11, 16'h1111, 4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_RD,  2'd0, 13'h003, 2'b00, 16'h0,    1'b0, 2'b11, 16'h2222, 4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b11, 16'h3333, 4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_WR,  2'd0, 13'h004, 2'b00, 16'hCAFE, 1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_RD,  2'd0, 13'h004, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b11, 16'hCAFE, 4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_ACT, 2'd0, 13'h003, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h2, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_PRE, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_ACT, 2'd0, 13'h003, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h8, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_RD,  2'd0, 13'h401, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b0, 2'b11, 16'h1111, 4'h0, 2'd2, 16'd5));
        tbl.push_back(mk(C_RD,  2'd0, 13'h001, 2'b00, 16'h0,    1'b0, 2'b00, 16'h0,    4'h1, 2'd2, 16'd5));
        tbl.push_back(mk(C_NOP, 2'd0, 13'h000, 2'b00, 16'h0,    1'b1, 2'b00, 16'h0,    4'h0, 2'd2, 16'd5));

        foreach (tbl[i]) begin
            cyc(tbl[i].cmd, tbl[i].ba, tbl[i].addr, tbl[i].dqm, tbl[i].dq, 1'b1, tbl[i].clr);
            check($sformatf("vec%0d dq_oe", i), 32'(bus.dq_oe), 32'(tbl[i].e_oe));
            if (tbl[i].e_oe != 2'b00)
                check($sformatf("vec%0d dq_o", i), 32'(bus.dq_o), 32'(tbl[i].e_dq));
            check($sformatf("vec%0d err_flags", i), 32'(err_flags), 32'(tbl[i].e_err));
            check($sformatf("vec%0d cas_latency", i), 32'(cas_latency), 32'(tbl[i].e_cl));
            check($sformatf("vec%0d refresh_count", i), 32'(refresh_count), 32'(tbl[i].e_ref));
        end
        check("mode_valid after table", 32'(mode_valid), 32'd1);

        // Clock suspend for two cycles during a CL=3 read delays the data by two cycles
        cyc(C_LMR, 2'd0, 13'h030, 2'b00, 16'h0, 1'b1, 1'b0);
        cyc(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0, 1'b1, 1'b0);
        nop();
        nop();
        cyc(C_RD, 2'd1, 13'h007, 2'b00, 16'h0, 1'b1, 1'b0);
        cyc(C_RD, 2'd1, 13'h007, 2'b00, 16'h0, 1'b0, 1'b0);
        check("cke0 edge1 dq_oe", 32'(bus.dq_oe), 32'h0);
        cyc(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0, 1'b0);
        check("cke0 edge2 dq_oe", 32'(bus.dq_oe), 32'h0);
        nop();
        check("cke resume edge3 dq_oe", 32'(bus.dq_oe), 32'h0);
        nop();
        check("cke delayed dq_oe", 32'(bus.dq_oe), 32'h3);
        check("cke delayed dq_o", 32'(bus.dq_o), 32'h12EF);
        nop();
        check("cke one-cycle dq_oe", 32'(bus.dq_oe), 32'h0);
        check("cke err_flags", 32'(err_flags), 32'h0);

        // Reset in the middle of a read drops the pending word; storage survives
        cyc(C_RD, 2'd1, 13'h007, 2'b00, 16'h0, 1'b1, 1'b0);
        rst = 1'b1;
        nop();
        check("midread reset dq_oe", 32'(bus.dq_oe), 32'h0);
        check("midread reset cas_latency", 32'(cas_latency), 32'd3);
        check("midread reset mode_valid", 32'(mode_valid), 32'd0);
        rst = 1'b0;
        nop();
        check("flushed pipeline dq_oe", 32'(bus.dq_oe), 32'h0);
        cyc(C_LMR, 2'd0, 13'h020, 2'b00, 16'h0, 1'b1, 1'b0);
        cyc(C_ACT, 2'd1, 13'h005, 2'b00, 16'h0, 1'b1, 1'b0);
        nop();
        nop();
        cyc(C_RD, 2'd1, 13'h007, 2'b00, 16'h0, 1'b1, 1'b0);
        nop();
        check("reinit read dq_oe", 32'(bus.dq_oe), 32'h3);
        check("reinit read dq_o", 32'(bus.dq_o), 32'h12EF);
        check("reinit err_flags", 32'(err_flags), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
